if_fetch_unit: RTL and testbench

//  Instruction-fetch stage that produces the PC4 and instr_code pair consumed by the IF/ID register.

---
 rtl/if_fetch_unit_pkg.sv | 36 +++
 rtl/if_fetch_unit_if.sv | 30 +++
 rtl/if_fetch_unit_btb.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 75 +++++++
 tb/tb_if_fetch_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP encoding, BTB counter states,
// BTB lookup/update bundles and the saturating counter helpers.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic        valid;
        logic [31:2] pc;
        logic        taken;
        logic [31:0] target;
    } btb_upd_t;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } btb_lkp_t;

    function automatic ctr_e sat_inc(input ctr_e c);
        return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
    endfunction

    function automatic ctr_e sat_dec(input ctr_e c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: stall/redirect and BTB training in from hazard/EX logic,
// fetch PC, PC4, instruction and prediction out to IF/ID.
interface if_fetch_unit_if;

    logic        pc_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_out;
    logic [31:0] PC4;
    logic [31:0] instr_code;
    logic        pred_taken;
    logic [31:0] pred_target;

    modport master (
        output pc_write, redirect, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        input  pc_out, PC4, instr_code, pred_taken, pred_target
    );

    modport slave (
        input  pc_write, redirect, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        output pc_out, PC4, instr_code, pred_taken, pred_target
    );

endinterface

// File: rtl/if_fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational from the stored state; updates land on the clock edge.
module if_fetch_unit_btb
    import if_fetch_unit_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] lk_pc,
    output btb_lkp_t    lk,
    input  btb_upd_t    upd
);

    localparam int IB = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IB;

    logic [BTB_ENTRIES-1:0]         valid_q, valid_d;
    logic [BTB_ENTRIES-1:0][TW-1:0] tag_q,   tag_d;
    logic [BTB_ENTRIES-1:0][31:0]   tgt_q,   tgt_d;
    ctr_e [BTB_ENTRIES-1:0]         ctr_q,   ctr_d;

    logic [IB-1:0] lk_idx, up_idx;
    logic [TW-1:0] lk_tag, up_tag;
    logic          up_hit;

    assign lk_idx = lk_pc[IB+1:2];
    assign lk_tag = lk_pc[31:IB+2];
    assign up_idx = upd.pc[IB+1:2];
    assign up_tag = upd.pc[31:IB+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads only the registered state, so a same-cycle update is not visible.
    always_comb begin
        lk.hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk.taken  = lk.hit && ctr_q[lk_idx][1];
        lk.target = tgt_q[lk_idx];
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        if (upd.valid) begin
            if (up_hit) begin
                if (upd.taken) begin
                    ctr_d[up_idx] = sat_inc(ctr_q[up_idx]);
                    tgt_d[up_idx] = upd.target;
                end else begin
                    ctr_d[up_idx] = sat_dec(ctr_q[up_idx]);
                end
            end else if (upd.taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = upd.target;
                ctr_d[up_idx]   = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= {BTB_ENTRIES{CTR_SNT}};
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            ctr_q   <= ctr_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, instruction ROM, BTB prediction and
// next-PC selection (redirect > stall > predicted target > PC+4).
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          IMEM_DEPTH  = 256,
    parameter int          BTB_ENTRIES = 16,
    // ROM image, word i at IMEM_INIT[i]; defaults to all NOPs
    parameter logic [IMEM_DEPTH-1:0][31:0] IMEM_INIT = {IMEM_DEPTH{NOP}}
) (
    input logic            clk,
    input logic            reset,
    if_fetch_unit_if.slave fif
);

    localparam int IW = $clog2(IMEM_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc4;
    logic [IW-1:0] rom_idx;
    btb_lkp_t      lk;
    btb_upd_t      upd;
    logic          unused_low_bits;

    assign pc4     = pc_q + 32'd4;
    assign rom_idx = pc_q[IW+1:2];

    assign upd.valid  = fif.upd_valid;
    assign upd.pc     = fif.upd_pc[31:2];
    assign upd.taken  = fif.upd_taken;
    assign upd.target = fif.upd_target;

    // Instructions are word aligned, so the byte-offset bits carry no information.
    assign unused_low_bits = ^{fif.redirect_pc[1:0], fif.upd_pc[1:0]};

    if_fetch_unit_btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk   (clk),
        .reset (reset),
        .lk_pc (pc_q[31:2]),
        .lk    (lk),
        .upd   (upd)
    );

    // A flush must win over a stall, otherwise a stalled wrong-path fetch sticks.
    always_comb begin
        pc_d = pc_q;
        if (fif.redirect) begin
            pc_d = {fif.redirect_pc[31:2], 2'b00};
        end else if (!fif.pc_write) begin
            pc_d = pc_q;
        end else if (lk.taken) begin
            pc_d = lk.target;
        end else begin
            pc_d = pc4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fif.pc_out      = pc_q;
    assign fif.PC4         = pc4;
    assign fif.instr_code  = IMEM_INIT[rom_idx];
    assign fif.pred_taken  = lk.taken;
    assign fif.pred_target = lk.target;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: ROM word i holds 32'hC0DE_0000 + i,
// 32-word ROM and 16-entry BTB.
module tb_if_fetch_unit;

    localparam int DEPTH = 32;

    function automatic logic [DEPTH-1:0][31:0] mk_rom();
        logic [DEPTH-1:0][31:0] r;
        for (int i = 0; i < DEPTH; i++) r[i] = 32'hC0DE_0000 + 32'(i);
        return r;
    endfunction

    localparam logic [DEPTH-1:0][31:0] ROM_IMG = mk_rom();

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    if_fetch_unit_if fif();

    if_fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_DEPTH  (DEPTH),
        .BTB_ENTRIES (16),
        .IMEM_INIT   (ROM_IMG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one rising edge, then settle at the falling edge where inputs change and outputs are sampled
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        fif.upd_valid  = v;
        fif.upd_pc     = pc;
        fif.upd_taken  = tk;
        fif.upd_target = tgt;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        fif.redirect    = 1'b1;
        fif.redirect_pc = pc;
        step();
        fif.redirect    = 1'b0;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        fif.pc_write    = 1'b0;
        fif.redirect    = 1'b0;
        fif.redirect_pc = '0;
        set_upd(1'b0, '0, 1'b0, '0);

        repeat (2) step();
        chk("rst_hold_pc", fif.pc_out, 32'h0);
        reset = 1'b1;
        fif.pc_write = 1'b1;
        #1;
        chk("rst_pc",    fif.pc_out,            32'h0);
        chk("rst_pc4",   fif.PC4,               32'h4);
        chk("rst_instr", fif.instr_code,        32'hC0DE_0000);
        chk("rst_pred",  {31'b0, fif.pred_taken}, 32'h0);

        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc",    fif.pc_out,     32'(i * 4));
            chk("seq_instr", fif.instr_code, 32'hC0DE_0000 + 32'(i));
        end

        fif.pc_write = 1'b0;
        step();
        chk("stall_hold", fif.pc_out, 32'h10);

        redirect_to(32'h47);
        chk("redir_in_stall", fif.pc_out,     32'h44);
        chk("redir_instr",    fif.instr_code, 32'hC0DE_0011);

        // allocate while redirecting to the branch itself
        fif.pc_write = 1'b1;
        set_upd(1'b1, 32'h8, 1'b1, 32'h40);
        redirect_to(32'h8);
        set_upd(1'b0, '0, 1'b0, '0);
        chk("alloc_pc",   fif.pc_out,              32'h8);
        chk("alloc_pred", {31'b0, fif.pred_taken}, 32'h1);
        chk("alloc_tgt",  fif.pred_target,         32'h40);
        step();
        chk("pred_follow", fif.pc_out,     32'h40);
        chk("pred_instr",  fif.instr_code, 32'hC0DE_0010);

        fif.pc_write = 1'b0;
        redirect_to(32'h8);
        step();
        chk("stall_over_pred", fif.pc_out, 32'h8);

        set_upd(1'b1, 32'h8, 1'b0, 32'h0);
        #1;
        chk("no_bypass", {31'b0, fif.pred_taken}, 32'h1);
        step();
        chk("nt1_ctr01", {31'b0, fif.pred_taken}, 32'h0);
        step();
        chk("nt2_ctr00", {31'b0, fif.pred_taken}, 32'h0);
        step();
        chk("nt3_ctr00", {31'b0, fif.pred_taken}, 32'h0);
        // a still-valid entry at 00 steps to 01, a dropped one would reallocate at 10
        set_upd(1'b1, 32'h8, 1'b1, 32'h80);
        step();
        chk("tk_from00", {31'b0, fif.pred_taken}, 32'h0);
        step();
        chk("tk_ctr10",  {31'b0, fif.pred_taken}, 32'h1);
        chk("tk_newtgt", fif.pred_target,         32'h80);
        step();
        step();
        set_upd(1'b1, 32'h8, 1'b0, 32'h0);
        step();
        chk("st_sat_nt1", {31'b0, fif.pred_taken}, 32'h1);
        step();
        chk("st_sat_nt2", {31'b0, fif.pred_taken}, 32'h0);
        set_upd(1'b1, 32'h8, 1'b1, 32'h80);
        step();
        set_upd(1'b0, '0, 1'b0, '0);
        chk("retrain", {31'b0, fif.pred_taken}, 32'h1);

        redirect_to(32'h48);
        chk("alias_miss", {31'b0, fif.pred_taken}, 32'h0);
        set_upd(1'b1, 32'h48, 1'b1, 32'h100);
        step();
        set_upd(1'b0, '0, 1'b0, '0);
        chk("alias_alloc", {31'b0, fif.pred_taken}, 32'h1);
        chk("alias_tgt",   fif.pred_target,         32'h100);
        fif.pc_write = 1'b1;
        redirect_to(32'h20);
        chk("redir_over_pred", fif.pc_out, 32'h20);
        fif.pc_write = 1'b0;
        redirect_to(32'h8);
        chk("alias_evict", {31'b0, fif.pred_taken}, 32'h0);

        redirect_to(32'hFFFF_FFFC);
        chk("wrap_pc4",   fif.PC4,        32'h0);
        chk("wrap_instr", fif.instr_code, 32'hC0DE_001F);
        fif.pc_write = 1'b1;
        step();
        chk("wrap_pc", fif.pc_out, 32'h0);

        fif.pc_write = 1'b0;
        redirect_to(32'h80);
        chk("rom_wrap", fif.instr_code, 32'hC0DE_0000);

        redirect_to(32'h48);
        chk("pre_rst_pred", {31'b0, fif.pred_taken}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_pc",   fif.pc_out,              32'h0);
        chk("midrst_pc4",  fif.PC4,                 32'h4);
        chk("midrst_pred", {31'b0, fif.pred_taken}, 32'h0);
        step();
        reset = 1'b1;
        redirect_to(32'h48);
        chk("btb_cleared", {31'b0, fif.pred_taken}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
